// File: rtl/signed_minmax_scheduler_if.sv
// ============================================================================
// Module   : signed_minmax_scheduler_if
// Purpose  : Sample-in / result-out handshake bundle for the signed min/max
//            frame tracker.
// Ports    : in_valid/in_ready/in_data/in_last   - sample stream
//            out_valid/out_ready/out_max/out_min/out_count - frame result
// Modports : slave  - the tracker (consumes samples, produces results)
//            master - the environment (produces samples, consumes results)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signed_minmax_scheduler_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_max;
  logic [N-1:0]  out_min;
  logic [CW-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count
  );
endinterface

`default_nettype wire

// File: rtl/signed_minmax_scheduler.sv
// ============================================================================
// Module   : signed_minmax_scheduler (+ comparatorSigned)
// Purpose  : Frame-based running max/min tracker over N-bit two's-complement
//            samples. A single signed comparator is time-shared between the
//            "new sample vs max" and "new sample vs min" checks, sequenced by
//            a five-state FSM. Reports {max, min, count} once per frame.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - signed_minmax_scheduler_if.slave (sample in, result out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparatorSigned #(
  parameter int N = 8
) (
  input  wire logic [N-1:0] x,
  input  wire logic [N-1:0] y,
  output logic              lt,
  output logic              gt
);
  assign lt = ($signed(x) < $signed(y));
  assign gt = ($signed(x) > $signed(y));
endmodule

module signed_minmax_scheduler #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  signed_minmax_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [N-1:0]  max_q;
  logic [N-1:0]  min_q;
  logic [N-1:0]  hold_q;
  logic [CW-1:0] count_q;
  logic          last_q;

  logic          accept_ok;
  logic          result_valid;
  logic          in_xfer;
  logic [N-1:0]  cmp_y;
  logic          cmp_lt;
  logic          cmp_gt;

  // The one shared comparator: x is always the held sample, y follows state.
  comparatorSigned #(.N(N)) u_cmp (
    .x  (hold_q),
    .y  (cmp_y),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  assign in_xfer = bus.in_valid & accept_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake outputs and comparator operand select
  always_comb begin
    state_d      = state_q;
    accept_ok    = 1'b0;
    result_valid = 1'b0;
    cmp_y        = max_q;
    case (state_q)
      S_IDLE: begin
        accept_ok = 1'b1;
        if (bus.in_valid) begin
          state_d = bus.in_last ? S_DONE : S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        accept_ok = 1'b1;
        if (bus.in_valid) begin
          state_d = S_CMP_MAX;
        end
      end
      S_CMP_MAX: begin
        cmp_y   = max_q;
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        cmp_y   = min_q;
        state_d = last_q ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: first sample seeds max/min directly; later samples are held
  // and folded in over the two compare cycles. Strict lt/gt means ties
  // keep the value already stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q   <= '0;
      min_q   <= '0;
      hold_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_xfer) begin
            max_q   <= bus.in_data;
            min_q   <= bus.in_data;
            count_q <= CW'(1);
          end
        end
        S_ACCEPT: begin
          if (in_xfer) begin
            hold_q <= bus.in_data;
            last_q <= bus.in_last;
          end
        end
        S_CMP_MAX: begin
          if (cmp_gt) begin
            max_q <= hold_q;
          end
        end
        S_CMP_MIN: begin
          if (cmp_lt) begin
            min_q <= hold_q;
          end
          // Saturate at all-ones rather than wrapping.
          if (count_q != {CW{1'b1}}) begin
            count_q <= count_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = accept_ok;
  assign bus.out_valid = result_valid;
  assign bus.out_max   = max_q;
  assign bus.out_min   = min_q;
  assign bus.out_count = count_q;

endmodule

`default_nettype wire
